// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// the load result-source code, the memory-wait FSM states and the
// forwarding priority function.
package pipeline_ctrl_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } memState_t;

    // Forward select for one E-stage source operand. M is younger than W,
    // so it wins when both hold the register. x0 is never forwarded.
    function automatic logic [1:0] fwdSelect(
        input logic [4:0] rsE,
        input logic [4:0] rdM,
        input logic       regWriteM,
        input logic [4:0] rdW,
        input logic       regWriteW
    );
        if (regWriteM && (rdM != 5'd0) && (rdM == rsE)) begin
            return FWD_M;
        end else if (regWriteW && (rdW != 5'd0) && (rdW == rsE)) begin
            return FWD_W;
        end else begin
            return FWD_RF;
        end
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_mem_wait.sv
// Data-memory wait tracker. Counts stall cycles for the access in M and
// force-releases it after MEM_TIMEOUT cycles, latching a sticky MemError.
//
// Handshake: MemAccessM is held high by the pipeline while a load/store sits
// in M; the access completes in the cycle where MemAccessM && MemReady are
// both high. MemReady is not required to stay high and carries no meaning
// when MemAccessM is low.
//
// The whole FSM state lives in one packed struct (r) so state, wait count and
// error flag can be probed together.
module mem_wait_fsm
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic MemAccessM,
    input  logic MemReady,
    output logic memStall,
    output logic MemError
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(MEM_TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    typedef struct packed {
        memState_t     state;
        logic [CW-1:0] waitCnt;
        logic          memError;
    } memWaitRegs_t;

    memWaitRegs_t r;
    memWaitRegs_t rNext;
    logic         timeoutHit;

    // State register; reset aborts any wait without flagging an error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r <= '{state: IDLE, waitCnt: '0, memError: 1'b0};
        end else begin
            r <= rNext;
        end
    end

    // Next-state, timeout detection and stall request.
    always_comb begin
        rNext      = r;
        timeoutHit = (r.state == WAIT) && (r.waitCnt == TIMEOUT_CNT);
        memStall   = MemAccessM && !MemReady && !timeoutHit;
        case (r.state)
            IDLE: begin
                if (MemAccessM && !MemReady) begin
                    rNext.state   = WAIT;
                    rNext.waitCnt = CNT_ONE;
                end
            end
            WAIT: begin
                if (MemReady || timeoutHit) begin
                    rNext.state   = IDLE;
                    rNext.waitCnt = '0;
                    if (timeoutHit) begin
                        rNext.memError = 1'b1;
                    end
                end else begin
                    rNext.waitCnt = r.waitCnt + CNT_ONE;
                end
            end
            default: begin
                rNext.state   = IDLE;
                rNext.waitCnt = '0;
            end
        endcase
    end

    assign MemError = r.memError;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage F/D/E/M/W pipeline:
// E-stage forwarding, load-use stalls, taken-branch flushes, data-memory
// wait with timeout, and stall/flush performance counters.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic             MemAccessM,
    input  logic             MemReady,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemError,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCycles
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic memStall;
    logic lwStall;

    mem_wait_fsm #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) uMemWait (
        .clk       (clk),
        .rst       (rst),
        .MemAccessM(MemAccessM),
        .MemReady  (MemReady),
        .memStall  (memStall),
        .MemError  (MemError)
    );

    // Load in E whose destination is read by the instruction in D.
    always_comb begin
        lwStall = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
                  ((RdE == Rs1D) || (RdE == Rs2D));
    end

    // Forwarding muxes for both E operands; parked on the register file in reset.
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (!rst) begin
            ForwardAE = fwdSelect(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
            ForwardBE = fwdSelect(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
        end
    end

    // Stall/flush outputs. A memory stall freezes F..M and bubbles W; any
    // branch flush waits because E (and PCSrcE) is frozen with it.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else if (memStall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = lwStall;
            StallD = lwStall;
            FlushE = lwStall || PCSrcE;
            FlushD = PCSrcE;
        end
    end

    // Performance counters; they wrap naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            StallCycles <= '0;
            FlushCycles <= '0;
        end else begin
            if (StallF) begin
                StallCycles <= StallCycles + CNT_ONE;
            end
            if (FlushE) begin
                FlushCycles <= FlushCycles + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Small timeout and counter width
// so the timeout and counter-wrap edges are reachable in a few cycles.
module tb_pipeline_hazard_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;

    // control bundle order: StallF StallD StallE StallM FlushD FlushE FlushW
    localparam logic [6:0] C_IDLE   = 7'b0000_000;
    localparam logic [6:0] C_RESET  = 7'b0000_111;
    localparam logic [6:0] C_LU     = 7'b1100_010;
    localparam logic [6:0] C_BR     = 7'b0000_110;
    localparam logic [6:0] C_LU_BR  = 7'b1100_110;
    localparam logic [6:0] C_MEM    = 7'b1111_001;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic             RegWriteM, RegWriteW;
    logic [1:0]       ResultSrcE;
    logic             PCSrcE, MemAccessM, MemReady;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushW;
    logic             MemError;
    logic [CNT_W-1:0] StallCycles, FlushCycles;

    logic [6:0]       ctl;
    assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

    int nVec = 0;
    int nErr = 0;
    logic [CNT_W-1:0] expStall;
    logic [CNT_W-1:0] expFlush;

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .RdM        (RdM),
        .RdW        (RdW),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .ResultSrcE (ResultSrcE),
        .PCSrcE     (PCSrcE),
        .MemAccessM (MemAccessM),
        .MemReady   (MemReady),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .FlushW     (FlushW),
        .MemError   (MemError),
        .StallCycles(StallCycles),
        .FlushCycles(FlushCycles)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clearInputs();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
        RdE = '0; RdM = '0; RdW = '0;
        RegWriteM = 1'b0; RegWriteW = 1'b0;
        ResultSrcE = 2'b00; PCSrcE = 1'b0;
        MemAccessM = 1'b0; MemReady = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clearInputs();
        rst = 1'b1;
        MemAccessM = 1'b1; PCSrcE = 1'b1;
        Rs1E = 5'd5; Rs2E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
        tick();
        tick();
        nVec++; if (ctl !== C_RESET) begin nErr++; $display("FAIL reset_ctl got %b want %b", ctl, C_RESET); end
        nVec++; if ({ForwardAE, ForwardBE} !== 4'b0000) begin nErr++; $display("FAIL reset_fwd got %b want %b", {ForwardAE, ForwardBE}, 4'b0000); end
        nVec++; if (StallCycles !== '0 || FlushCycles !== '0) begin nErr++; $display("FAIL reset_cnt got %0d/%0d want 0/0", StallCycles, FlushCycles); end
        nVec++; if (MemError !== 1'b0) begin nErr++; $display("FAIL reset_memerr got %b want 0", MemError); end
        clearInputs();
        rst = 1'b0;
        settle();
        nVec++; if (ctl !== C_IDLE) begin nErr++; $display("FAIL idle_ctl got %b want %b", ctl, C_IDLE); end
        tick();
        expStall = '0;
        expFlush = '0;
        nVec++; if (StallCycles !== expStall || FlushCycles !== expFlush) begin nErr++; $display("FAIL idle_cnt got %0d/%0d want %0d/%0d", StallCycles, FlushCycles, expStall, expFlush); end
    endtask

    task automatic test_forwarding();
        clearInputs();
        Rs1E = 5'd5; RdM = 5'd5; RdW = 5'd5; RegWriteM = 1'b1; RegWriteW = 1'b1;
        settle();
        nVec++; if (ForwardAE !== 2'b10) begin nErr++; $display("FAIL fwd_m_prio got %b want 10", ForwardAE); end
        nVec++; if (ForwardBE !== 2'b00) begin nErr++; $display("FAIL fwd_b_none got %b want 00", ForwardBE); end
        RegWriteM = 1'b0;
        settle();
        nVec++; if (ForwardAE !== 2'b01) begin nErr++; $display("FAIL fwd_w got %b want 01", ForwardAE); end
        RegWriteM = 1'b1; RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0;
        settle();
        nVec++; if ({ForwardAE, ForwardBE} !== 4'b0000) begin nErr++; $display("FAIL fwd_x0 got %b want 0000", {ForwardAE, ForwardBE}); end
        Rs1E = 5'd3; RdW = 5'd3; Rs2E = 5'd9; RdM = 5'd9;
        settle();
        nVec++; if ({ForwardAE, ForwardBE} !== 4'b0110) begin nErr++; $display("FAIL fwd_split got %b want 0110", {ForwardAE, ForwardBE}); end
        Rs2E = 5'd12; RdM = 5'd12; RdW = 5'd12;
        settle();
        nVec++; if ({ForwardAE, ForwardBE} !== 4'b0010) begin nErr++; $display("FAIL fwd_b_prio got %b want 0010", {ForwardAE, ForwardBE}); end
        nVec++; if (ctl !== C_IDLE) begin nErr++; $display("FAIL fwd_no_hazard got %b want %b", ctl, C_IDLE); end
        tick();
        clearInputs();
    endtask

    task automatic test_load_use();
        clearInputs();
        ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
        settle();
        nVec++; if (ctl !== C_LU) begin nErr++; $display("FAIL lu_rs2 got %b want %b", ctl, C_LU); end
        tick();
        expStall = expStall + 1'b1;
        expFlush = expFlush + 1'b1;
        clearInputs();
        settle();
        nVec++; if (ctl !== C_IDLE) begin nErr++; $display("FAIL lu_one_cycle got %b want %b", ctl, C_IDLE); end
        nVec++; if (StallCycles !== expStall || FlushCycles !== expFlush) begin nErr++; $display("FAIL lu_cnt got %0d/%0d want %0d/%0d", StallCycles, FlushCycles, expStall, expFlush); end
        ResultSrcE = 2'b01; RdE = 5'd0;
        settle();
        nVec++; if (ctl !== C_IDLE) begin nErr++; $display("FAIL lu_rd0 got %b want %b", ctl, C_IDLE); end
        tick();
        nVec++; if (StallCycles !== expStall || FlushCycles !== expFlush) begin nErr++; $display("FAIL lu_rd0_cnt got %0d/%0d want %0d/%0d", StallCycles, FlushCycles, expStall, expFlush); end
        ResultSrcE = 2'b10; RdE = 5'd7; Rs1D = 5'd7;
        settle();
        nVec++; if (ctl !== C_IDLE) begin nErr++; $display("FAIL lu_not_load got %b want %b", ctl, C_IDLE); end
        ResultSrcE = 2'b01;
        settle();
        nVec++; if (ctl !== C_LU) begin nErr++; $display("FAIL lu_rs1 got %b want %b", ctl, C_LU); end
        tick();
        expStall = expStall + 1'b1;
        expFlush = expFlush + 1'b1;
        clearInputs();
    endtask

    task automatic test_branch();
        clearInputs();
        PCSrcE = 1'b1;
        settle();
        nVec++; if (ctl !== C_BR) begin nErr++; $display("FAIL branch got %b want %b", ctl, C_BR); end
        tick();
        expFlush = expFlush + 1'b1;
        ResultSrcE = 2'b01; RdE = 5'd3; Rs1D = 5'd3;
        settle();
        nVec++; if (ctl !== C_LU_BR) begin nErr++; $display("FAIL lu_branch got %b want %b", ctl, C_LU_BR); end
        tick();
        expStall = expStall + 1'b1;
        expFlush = expFlush + 1'b1;
        clearInputs();
        settle();
        nVec++; if (StallCycles !== expStall || FlushCycles !== expFlush) begin nErr++; $display("FAIL branch_cnt got %0d/%0d want %0d/%0d", StallCycles, FlushCycles, expStall, expFlush); end
    endtask

    task automatic test_mem_wait();
        clearInputs();
        MemAccessM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            nVec++; if (ctl !== C_MEM) begin nErr++; $display("FAIL memwait_c%0d got %b want %b", i + 1, ctl, C_MEM); end
            tick();
            expStall = expStall + 1'b1;
        end
        MemReady = 1'b1;
        settle();
        nVec++; if (ctl !== C_IDLE) begin nErr++; $display("FAIL memwait_release got %b want %b", ctl, C_IDLE); end
        tick();
        clearInputs();
        settle();
        nVec++; if (MemError !== 1'b0) begin nErr++; $display("FAIL memwait_err got %b want 0", MemError); end
        nVec++; if (StallCycles !== expStall || FlushCycles !== expFlush) begin nErr++; $display("FAIL memwait_cnt got %0d/%0d want %0d/%0d", StallCycles, FlushCycles, expStall, expFlush); end
    endtask

    task automatic test_timeout();
        clearInputs();
        MemAccessM = 1'b1;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            settle();
            nVec++; if (ctl !== C_MEM || MemError !== 1'b0) begin nErr++; $display("FAIL timeout_c%0d got %b/%b want %b/0", i + 1, ctl, MemError, C_MEM); end
            tick();
            expStall = expStall + 1'b1;
        end
        settle();
        nVec++; if (ctl !== C_IDLE) begin nErr++; $display("FAIL timeout_release got %b want %b", ctl, C_IDLE); end
        tick();
        clearInputs();
        settle();
        nVec++; if (MemError !== 1'b1) begin nErr++; $display("FAIL timeout_err got %b want 1", MemError); end
        PCSrcE = 1'b1;
        tick();
        expFlush = expFlush + 1'b1;
        clearInputs();
        tick();
        nVec++; if (MemError !== 1'b1) begin nErr++; $display("FAIL timeout_sticky got %b want 1", MemError); end
        nVec++; if (StallCycles !== expStall || FlushCycles !== expFlush) begin nErr++; $display("FAIL timeout_cnt got %0d/%0d want %0d/%0d", StallCycles, FlushCycles, expStall, expFlush); end
    endtask

    task automatic test_branch_during_wait();
        clearInputs();
        MemAccessM = 1'b1; PCSrcE = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            nVec++; if (ctl !== C_MEM) begin nErr++; $display("FAIL brwait_c%0d got %b want %b", i + 1, ctl, C_MEM); end
            tick();
            expStall = expStall + 1'b1;
        end
        MemReady = 1'b1;
        settle();
        nVec++; if (ctl !== C_BR) begin nErr++; $display("FAIL brwait_release got %b want %b", ctl, C_BR); end
        tick();
        expFlush = expFlush + 1'b1;
        clearInputs();
        settle();
        nVec++; if (StallCycles !== expStall || FlushCycles !== expFlush) begin nErr++; $display("FAIL brwait_cnt got %0d/%0d want %0d/%0d", StallCycles, FlushCycles, expStall, expFlush); end
    endtask

    task automatic test_reset_mid_wait();
        clearInputs();
        MemAccessM = 1'b1;
        tick();
        settle();
        nVec++; if (ctl !== C_MEM) begin nErr++; $display("FAIL rstwait_pre got %b want %b", ctl, C_MEM); end
        rst = 1'b1;
        Rs1E = 5'd9; RdM = 5'd9; RegWriteM = 1'b1;
        settle();
        nVec++; if (ctl !== C_RESET || ForwardAE !== 2'b00) begin nErr++; $display("FAIL rstwait_ctl got %b/%b want %b/00", ctl, ForwardAE, C_RESET); end
        tick();
        nVec++; if (StallCycles !== '0 || FlushCycles !== '0 || MemError !== 1'b0) begin nErr++; $display("FAIL rstwait_clr got %0d/%0d/%b want 0/0/0", StallCycles, FlushCycles, MemError); end
        tick();
        clearInputs();
        rst = 1'b0;
        expStall = '0;
        expFlush = '0;
        // A fresh access must stall the full timeout again: the wait count restarted.
        MemAccessM = 1'b1;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            settle();
            nVec++; if (ctl !== C_MEM) begin nErr++; $display("FAIL rstwait_fresh_c%0d got %b want %b", i + 1, ctl, C_MEM); end
            tick();
            expStall = expStall + 1'b1;
        end
        settle();
        nVec++; if (ctl !== C_IDLE) begin nErr++; $display("FAIL rstwait_fresh_release got %b want %b", ctl, C_IDLE); end
        tick();
        clearInputs();
        settle();
        nVec++; if (StallCycles !== expStall || MemError !== 1'b1) begin nErr++; $display("FAIL rstwait_fresh_end got %0d/%b want %0d/1", StallCycles, MemError, expStall); end
    endtask

    task automatic test_counter_wrap();
        clearInputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ResultSrcE = 2'b01; RdE = 5'd4; Rs2D = 5'd4;
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        nVec++; if (StallCycles !== 4'hF || FlushCycles !== 4'hF) begin nErr++; $display("FAIL wrap_max got %0d/%0d want 15/15", StallCycles, FlushCycles); end
        tick();
        nVec++; if (StallCycles !== 4'h0 || FlushCycles !== 4'h0) begin nErr++; $display("FAIL wrap_zero got %0d/%0d want 0/0", StallCycles, FlushCycles); end
        clearInputs();
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        expStall = '0;
        expFlush = '0;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_branch_during_wait();
        test_reset_mid_wait();
        test_counter_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline (F/D/E/M/W).
- Outputs drive the enable and clear pins of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the E-stage forwarding muxes.
- Handles forwarding, load-use stalls, taken-branch flushes, and a variable-latency data-memory wait with timeout.
- Keeps two performance counters.

Parameters:
- MEM_TIMEOUT, 16, maximum stall cycles for one data-memory access before forced release (≥2).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- Rs1D, Rs2D  in  5  source registers in D.
- Rs1E, Rs2E, RdE  in  5  source and destination registers in E.
- RdM, RdW  in  5  destination registers in M and W.
- RegWriteM, RegWriteW  in  1  register-write enables in M and W.
- ResultSrcE  in  2  result select in E; 2'b01 = load.
- PCSrcE  in  1  branch/jump taken, resolved in E.
- MemAccessM  in  1  load or store present in M.
- MemReady  in  1  data memory completes the current access this cycle.
- ForwardAE, ForwardBE  out  2  forwarding select: 00 register file, 01 from W, 10 from M.
- StallF, StallD, StallE, StallM  out  1  hold the PC / IF-ID / ID-EX / EX-MEM registers.
- FlushD, FlushE, FlushW  out  1  clear IF-ID / ID-EX / MEM-WB.
- MemError  out  1  sticky flag: a memory access timed out.
- StallCycles, FlushCycles  out  CNT_W  performance counters.

Behaviour:
- Forwarding (combinational), evaluated independently for A (Rs1E) and B (Rs2E):
  - 10 if RegWriteM, RdM != 0 and RdM == RsxE.
  - else 01 if RegWriteW, RdW != 0 and RdW == RsxE.
  - else 00.
  - M has priority over W.
- Load-use hazard: lw_stall = (ResultSrcE == 01) and RdE != 0 and (RdE == Rs1D or RdE == Rs2D).
- Memory stall:
  - mem_stall = MemAccessM and !MemReady and !timeout_hit.
  - timeout_hit = (state == WAIT and wait_cnt == MEM_TIMEOUT).
- FSM states: IDLE, WAIT. The counter is wait_cnt, width clog2(MEM_TIMEOUT+1).
  - IDLE: if MemAccessM and !MemReady, go to WAIT with wait_cnt = 1. Otherwise stay.
  - WAIT: if MemReady or timeout_hit, go to IDLE with wait_cnt = 0; on timeout_hit also set MemError. Otherwise wait_cnt++.
  - Result: an access that never completes stalls exactly MEM_TIMEOUT cycles and is released on cycle MEM_TIMEOUT+1.
- Output equations, with mem_stall dominant:
  - If mem_stall: StallF = StallD = StallE = StallM = 1, FlushW = 1, FlushD = FlushE = 0.
  - Else:
    - StallF = StallD = lw_stall.
    - StallE = StallM = 0, FlushW = 0.
    - FlushE = lw_stall or PCSrcE.
    - FlushD = PCSrcE.
- Simultaneous events:
  - Branch taken during a mem_stall: the flush is deferred. E is frozen, so PCSrcE stays high and FlushD/FlushE assert on the first non-stalled cycle.
  - Load-use and branch together: FlushE = 1, FlushD = 1, StallF = StallD = 1.
- Counters:
  - StallCycles increments in every cycle where StallF = 1.
  - FlushCycles increments in every cycle where FlushE = 1.
  - Both wrap modulo 2^CNT_W.
- Reset (synchronous, rst = 1 at a clk edge):
  - state = IDLE, wait_cnt = 0, MemError = 0, both counters = 0.
  - While rst is high: all Stall outputs = 0; FlushD = FlushE = FlushW = 1; ForwardAE = ForwardBE = 00.
  - Reset in WAIT aborts the wait and no MemError is set.
- MemError is cleared only by rst.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10.
  - RESULT_SRC_LOAD = 2'b01.
  - FSM state encoding: IDLE = 1'b0, WAIT = 1'b1.
- One sub-module, mem_wait_fsm, contains the state, wait_cnt, timeout_hit, mem_stall and MemError.
- The top level holds forwarding, load-use detection, output muxing and the counters.

Test Plan:
- Forwarding priority: RdM = RdW = Rs1E = 5, RegWriteM = RegWriteW = 1 → ForwardAE = 10. Drop RegWriteM → 01. Set RdM = RdW = 0 → 00.
- Load-use: ResultSrcE = 01, RdE = 7, Rs2D = 7 → StallF = StallD = FlushE = 1 for one cycle; StallCycles and FlushCycles each +1. Same stimulus with RdE = 0 → no stall.
- Branch flush: PCSrcE = 1 with no other hazard → FlushD = FlushE = 1, no stalls.
- Memory wait: MemAccessM = 1, MemReady low for 3 cycles then high → all four stalls and FlushW high for exactly 3 cycles, released on cycle 4, MemError = 0, StallCycles = 3.
- Timeout: MEM_TIMEOUT = 4, MemReady held 0 → stalls for 4 cycles, released on cycle 5, MemError = 1 and stays 1 until rst.
- Branch during mem wait plus reset: PCSrcE = 1 during a 2-cycle wait → FlushD/FlushE stay 0 while stalled, then 1 on the release cycle. Assert rst mid-wait → state IDLE, counters 0, FlushD = FlushE = FlushW = 1 while rst is high.
